// File: rtl/rover_vision_pkg.sv
// Shared types and default frame geometry for the rover vision pipeline.
// Used by the colour/blur stage and by red_bbox_tracker.
package rover_vision_pkg;

    localparam int DEFAULT_IMAGE_W = 640;
    localparam int DEFAULT_IMAGE_H = 480;
    localparam int DEFAULT_COORD_W = 11;

    typedef logic [DEFAULT_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t left;
        coord_t right;
        coord_t top;
        coord_t bottom;
        logic   found;
    } bbox_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } trk_state_t;

endpackage

// File: rtl/red_run_filter.sv
// Horizontal run filter: a red beat counts only once RUN_MIN consecutive red
// beats have been seen in the current row.
module red_run_filter #(
    parameter int RUN_MIN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic beat,
    input  logic red_sector,
    input  logic row_start,
    output logic counted,
    output logic run_reached
);

    localparam logic [3:0] RUN_SAT = 4'(RUN_MIN);

    logic [3:0] run_q;
    logic [3:0] run_base;
    logic [3:0] run_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        run_base    = row_start ? 4'd0 : run_q;
        run_d       = 4'd0;
        if (red_sector) begin
            run_d = (run_base >= RUN_SAT) ? RUN_SAT : run_base + 4'd1;
        end
        counted     = beat && red_sector && (run_d >= RUN_SAT);
        // The run has just reached RUN_MIN: this beat closes the first qualifying window.
        run_reached = counted && (run_base == RUN_SAT - 4'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 4'd0;
        end else if (beat) begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/red_bbox_tracker.sv
// Per-frame bounding box of run-filtered red pixels, published with a one-cycle strobe.
// Optional centroid sums are built when RED_CENTROID_EN is defined.
module red_bbox_tracker
    import rover_vision_pkg::*;
#(
    parameter int IMAGE_W    = DEFAULT_IMAGE_W,
    parameter int IMAGE_H    = DEFAULT_IMAGE_H,
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int RUN_MIN    = 4,
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic               packet_video,
    input  logic               sop,
    input  logic               eop,
    input  logic               red_sector,
    output logic               frame_valid,
    output logic               bbox_found,
    output logic [COORD_W-1:0] bbox_left,
    output logic [COORD_W-1:0] bbox_right,
    output logic [COORD_W-1:0] bbox_top,
    output logic [COORD_W-1:0] bbox_bottom,
    output logic [CNT_W-1:0]   pixel_count,
    output logic [31:0]        sum_x,
    output logic [31:0]        sum_y
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMAGE_H - 1);
    localparam logic [COORD_W-1:0] LEFT_OFS = COORD_W'(RUN_MIN - 1);

    trk_state_t state_q, state_d;
    logic       publish;

    logic beat, frame_start, active, row_wrap, row_start;
    logic counted, run_reached;
    logic [COORD_W-1:0] cur_x, cur_y, pix_x, pix_y, left_cand;

    logic [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
    logic [COORD_W-1:0] min_x_d, max_x_d, min_y_d, max_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_base, cnt_d;
    logic               found_d;

    assign beat        = in_valid && packet_video;
    assign frame_start = beat && sop;
    assign active      = frame_start || (beat && (state_q == ACCUM));
    assign row_wrap    = (cur_x == X_LAST);
    assign row_start   = frame_start || row_wrap;

    always_comb begin
        pix_x = cur_x + COORD_W'(1);
        pix_y = cur_y;
        if (frame_start) begin
            pix_x = '0;
            pix_y = '0;
        end else if (row_wrap) begin
            pix_x = '0;
            // Oversized frames pin y at the last row instead of wrapping.
            pix_y = (cur_y == Y_LAST) ? cur_y : cur_y + COORD_W'(1);
        end
        left_cand = run_reached ? pix_x - LEFT_OFS : pix_x;
    end

    red_run_filter #(.RUN_MIN(RUN_MIN)) u_run_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .beat        (active),
        .red_sector  (red_sector),
        .row_start   (row_start),
        .counted     (counted),
        .run_reached (run_reached)
    );

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (eop) publish = 1'b1;
                    else     state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat && eop) begin
                    publish = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A sop beat discards the running frame, so the accumulators start from zero on that beat.
    always_comb begin
        cnt_base = frame_start ? '0 : cnt_q;
        cnt_d    = cnt_base;
        min_x_d  = frame_start ? '0 : min_x_q;
        max_x_d  = frame_start ? '0 : max_x_q;
        min_y_d  = frame_start ? '0 : min_y_q;
        max_y_d  = frame_start ? '0 : max_y_q;
        if (counted) begin
            if (cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
            if (cnt_base == '0) begin
                min_x_d = left_cand;
                max_x_d = pix_x;
                min_y_d = pix_y;
                max_y_d = pix_y;
            end else begin
                if (left_cand < min_x_d) min_x_d = left_cand;
                if (pix_x > max_x_d)     max_x_d = pix_x;
                if (pix_y < min_y_d)     min_y_d = pix_y;
                if (pix_y > max_y_d)     max_y_d = pix_y;
            end
        end
        found_d = (cnt_d >= CNT_W'(MIN_PIXELS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            cnt_q   <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
        end else begin
            state_q <= state_d;
            if (active) begin
                cur_x   <= pix_x;
                cur_y   <= pix_y;
                cnt_q   <= cnt_d;
                min_x_q <= min_x_d;
                max_x_q <= max_x_d;
                min_y_q <= min_y_d;
                max_y_q <= max_y_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            bbox_found  <= 1'b0;
            bbox_left   <= '0;
            bbox_right  <= '0;
            bbox_top    <= '0;
            bbox_bottom <= '0;
            pixel_count <= '0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                bbox_found  <= found_d;
                bbox_left   <= found_d ? min_x_d : '0;
                bbox_right  <= found_d ? max_x_d : '0;
                bbox_top    <= found_d ? min_y_d : '0;
                bbox_bottom <= found_d ? max_y_d : '0;
                pixel_count <= cnt_d;
            end
        end
    end

`ifdef RED_CENTROID_EN
    logic [31:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;

    always_comb begin
        acc_x_d = frame_start ? 32'd0 : acc_x_q;
        acc_y_d = frame_start ? 32'd0 : acc_y_q;
        if (counted) begin
            acc_x_d = acc_x_d + 32'(pix_x);
            acc_y_d = acc_y_d + 32'(pix_y);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_x_q <= '0;
            acc_y_q <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
        end else begin
            if (active) begin
                acc_x_q <= acc_x_d;
                acc_y_q <= acc_y_d;
            end
            if (publish) begin
                sum_x <= acc_x_d;
                sum_y <= acc_y_d;
            end
        end
    end
`else
    assign sum_x = 32'd0;
    assign sum_y = 32'd0;
`endif

endmodule
